uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: byte-wide UART transmitter with a valid/ready request port.
// Sends 8N1 frames by default; define UART_TX_PARITY_EN to insert an
// even-parity bit between the last data bit and the stop bit (8E1).
// When a stop bit ends and a new byte is already offered, that byte is
// taken on the same edge so its start bit follows with no idle cycle.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_tx_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          take;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Next-state: bit timing, serialisation and byte acceptance
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    take    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (timer_q == T_LAST);

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        take  = i_tx_valid;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          take    = i_tx_valid;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Acceptance overrides: capture the byte and drive the start bit
    if (take) begin
      state_d = S_START;
      timer_d = '0;
      idx_d   = '0;
      shift_d = i_tx_data;
      txd_d   = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = ^i_tx_data;
`endif
    end
  end

  // State and output registers, asynchronously reset to an idle line
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_txd      = txd_q;
  assign o_tx_ready = ready_q;
  assign o_busy     = busy_q;
  assign o_tx_done  = done_q;

endmodule
